pipe_flow_ctrl: RTL and testbench

Parametrised pipeline flow controller for the in-order RV32 core. It generalises the single-source jump and stall logic to:
- N redirect sources with fixed priority;
- per-stage stall and flush vectors;
- a registered I-cache miss FSM that replaces the level-latched stall flag;
- a pending-redirect register for jumps that arrive during an outstanding fetch.

It sits beside the pipeline registers and drives the PC mux, the IF/ID..MEM/WB registers and the I-cache.

---
 rtl/pipe_flow_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - redirect arbitration, stall/flush and I-cache miss FSM for the RV32 pipeline
// Optional perf counters are enabled with `define FC_PERF_CNT_EN.
module pipe_flow_ctrl #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 5,
  parameter int NUM_REDIR  = 2,
  parameter logic [NUM_REDIR*4-1:0] REDIR_FLUSH_DEPTH = {4'd1, 4'd2}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  input  logic                      if_req_i,
  input  logic                      icache_ready_i,
  input  logic                      dmem_busy_i,
  output logic [NUM_STAGES-1:0]     fc_stall_o,
  output logic [NUM_STAGES-1:0]     fc_flush_o,
  output logic                      fc_redir_valid_o,
  output logic [XLEN-1:0]           fc_redir_pc_o,
  output logic                      fc_fetch_kill_o,
`ifdef FC_PERF_CNT_EN
  output logic [31:0]               perf_miss_cyc_o,
  output logic [31:0]               perf_flush_cnt_o,
`endif
  output logic [1:0]                fc_miss_state_o
);

  localparam int SW = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    KILL   = 2'd2,
    REPLAY = 2'd3
  } state_t;

  state_t          state, next_state;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [SW-1:0]   pend_src;

  logic            any_redir, redir_ok, fetch_miss;
  logic [SW-1:0]   win;
  logic [XLEN-1:0] win_pc;
  logic [3:0]      win_depth;

  logic fe_stall, use_win_flush, take_win, take_pend, kill, latch_pend, replay_flush;
  logic [NUM_STAGES-1:0] stall_raw, flush_raw;
  logic [XLEN-1:0]       pc_raw;

  // Scanning downwards lets the lowest-index (highest-priority) source win.
  always_comb begin
    any_redir = 1'b0;
    win       = '0;
    for (int r = NUM_REDIR - 1; r >= 0; r--) begin
      if (redir_valid_i[r]) begin
        any_redir = 1'b1;
        win       = SW'(r);
      end
    end
  end

  assign win_pc     = redir_pc_i[int'(win)*XLEN +: XLEN];
  assign win_depth  = REDIR_FLUSH_DEPTH[int'(win)*4 +: 4];
  assign redir_ok   = any_redir & ~dmem_busy_i;
  assign fetch_miss = if_req_i & ~icache_ready_i;

  always_comb begin
    next_state    = state;
    fe_stall      = 1'b0;
    use_win_flush = 1'b0;
    take_win      = 1'b0;
    take_pend     = 1'b0;
    kill          = 1'b0;
    latch_pend    = 1'b0;
    replay_flush  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_miss) begin
          fe_stall   = 1'b1;
          next_state = MISS;
          if (redir_ok) begin
            use_win_flush = 1'b1;
            latch_pend    = 1'b1;
            next_state    = KILL;
          end
        end else if (redir_ok) begin
          use_win_flush = 1'b1;
          take_win      = 1'b1;
        end
      end
      MISS: begin
        fe_stall = ~icache_ready_i;
        if (redir_ok) begin
          use_win_flush = 1'b1;
          latch_pend    = 1'b1;
          if (icache_ready_i) begin
            kill       = 1'b1;
            next_state = REPLAY;
          end else begin
            next_state = KILL;
          end
        end else if (icache_ready_i) begin
          next_state = IDLE;
        end
      end
      KILL: begin
        // Only a strictly higher-priority source may replace the pending target.
        if (redir_ok && (!pend_valid || win < pend_src)) begin
          use_win_flush = 1'b1;
          latch_pend    = 1'b1;
        end
        if (icache_ready_i) begin
          kill       = 1'b1;
          next_state = REPLAY;
        end else begin
          fe_stall = 1'b1;
        end
      end
      REPLAY: begin
        if (!dmem_busy_i) begin
          next_state   = IDLE;
          replay_flush = 1'b1;
          if (redir_ok) begin
            use_win_flush = 1'b1;
            take_win      = 1'b1;
          end else begin
            take_pend = pend_valid;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    flush_raw = '0;
    for (int i = 1; i < NUM_STAGES; i++) begin
      flush_raw[i] = use_win_flush && (i <= int'(win_depth));
    end
    flush_raw[1]            = flush_raw[1] | replay_flush;
    flush_raw[NUM_STAGES-1] = flush_raw[NUM_STAGES-1] | dmem_busy_i;

    stall_raw = '0;
    if (dmem_busy_i) stall_raw[NUM_STAGES-2:0] = '1;
    if (fe_stall)    stall_raw[1:0] = 2'b11;
    stall_raw = stall_raw & ~flush_raw;

    pc_raw = '0;
    if (take_win)       pc_raw = win_pc;
    else if (take_pend) pc_raw = pend_pc;
  end

  assign fc_stall_o       = rst ? '0 : stall_raw;
  assign fc_flush_o       = rst ? '0 : flush_raw;
  assign fc_redir_valid_o = ~rst & (take_win | take_pend);
  assign fc_redir_pc_o    = rst ? '0 : pc_raw;
  assign fc_fetch_kill_o  = ~rst & kill;
  assign fc_miss_state_o  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      pend_src   <= '0;
    end else begin
      state <= next_state;
      if (latch_pend) begin
        pend_valid <= 1'b1;
        pend_pc    <= win_pc;
        pend_src   <= win;
      end else if (state == REPLAY && !dmem_busy_i) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef FC_PERF_CNT_EN
  logic [31:0] miss_cyc, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cyc  <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == MISS || state == KILL) && miss_cyc != 32'hFFFF_FFFF)
        miss_cyc <= miss_cyc + 32'd1;
      if ((|flush_raw) && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_miss_cyc_o  = miss_cyc;
  assign perf_flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - directed scoreboard bench for pipe_flow_ctrl
module tb_pipe_flow_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  redir_valid_i;
  logic [63:0] redir_pc_i;
  logic        if_req_i, icache_ready_i, dmem_busy_i;
  logic [4:0]  fc_stall_o, fc_flush_o;
  logic        fc_redir_valid_o, fc_fetch_kill_o;
  logic [31:0] fc_redir_pc_o;
  logic [1:0]  fc_miss_state_o;
`ifdef FC_PERF_CNT_EN
  logic [31:0] perf_miss_cyc_o, perf_flush_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        rv;
    logic [31:0] pc;
    logic        kill;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];

  pipe_flow_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .redir_valid_i    (redir_valid_i),
    .redir_pc_i       (redir_pc_i),
    .if_req_i         (if_req_i),
    .icache_ready_i   (icache_ready_i),
    .dmem_busy_i      (dmem_busy_i),
    .fc_stall_o       (fc_stall_o),
    .fc_flush_o       (fc_flush_o),
    .fc_redir_valid_o (fc_redir_valid_o),
    .fc_redir_pc_o    (fc_redir_pc_o),
    .fc_fetch_kill_o  (fc_fetch_kill_o),
`ifdef FC_PERF_CNT_EN
    .perf_miss_cyc_o  (perf_miss_cyc_o),
    .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
    .fc_miss_state_o  (fc_miss_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    assert (fc_stall_o === e.stall) else begin
      failures++; $error("FAIL %s stall got=%b exp=%b", e.tag, fc_stall_o, e.stall);
    end
    checks++;
    assert (fc_flush_o === e.flush) else begin
      failures++; $error("FAIL %s flush got=%b exp=%b", e.tag, fc_flush_o, e.flush);
    end
    checks++;
    assert (fc_redir_valid_o === e.rv) else begin
      failures++; $error("FAIL %s redir_valid got=%b exp=%b", e.tag, fc_redir_valid_o, e.rv);
    end
    checks++;
    assert (fc_redir_pc_o === e.pc) else begin
      failures++; $error("FAIL %s redir_pc got=%h exp=%h", e.tag, fc_redir_pc_o, e.pc);
    end
    checks++;
    assert (fc_fetch_kill_o === e.kill) else begin
      failures++; $error("FAIL %s kill got=%b exp=%b", e.tag, fc_fetch_kill_o, e.kill);
    end
    checks++;
    assert (fc_miss_state_o === e.st) else begin
      failures++; $error("FAIL %s state got=%0d exp=%0d", e.tag, fc_miss_state_o, e.st);
    end
  endtask

  // ctl = {if_req, icache_ready, dmem_busy}; expectations describe the cycle being driven.
  task automatic step(input string tag, input logic r, input logic [1:0] v,
                      input logic [31:0] p0, input logic [31:0] p1, input logic [2:0] ctl,
                      input logic [4:0] es, input logic [4:0] ef, input logic erv,
                      input logic [31:0] epc, input logic ek, input logic [1:0] est);
    exp_t e;
    @(negedge clk);
    rst            = r;
    redir_valid_i  = v;
    redir_pc_i     = {p1, p0};
    if_req_i       = ctl[2];
    icache_ready_i = ctl[1];
    dmem_busy_i    = ctl[0];
    e.tag = tag; e.stall = es; e.flush = ef; e.rv = erv; e.pc = epc; e.kill = ek; e.st = est;
    exp_q.push_back(e);
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1; redir_valid_i = '0; redir_pc_i = '0;
    if_req_i = 1'b0; icache_ready_i = 1'b0; dmem_busy_i = 1'b0;

    step("rst",       1, 2'b00, 0, 0, 3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);
    step("idle",      0, 2'b00, 0, 0, 3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Simultaneous redirects: source 0 wins, flushes stages 1..2.
    step("dual",      0, 2'b11, 32'h100, 32'h200, 3'b000, 5'b00000, 5'b00110, 1, 32'h100, 0, 0);
    step("jal_only",  0, 2'b10, 0, 32'h200,       3'b000, 5'b00000, 5'b00010, 1, 32'h200, 0, 0);

    // Plain miss: four stalled cycles, release on ready.
    step("m_start",   0, 2'b00, 0, 0, 3'b100, 5'b00011, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("m_hold",  0, 2'b00, 0, 0, 3'b100, 5'b00011, 5'b00000, 0, 0, 0, 1);
    step("m_ready",   0, 2'b00, 0, 0, 3'b110, 5'b00000, 5'b00000, 0, 0, 0, 1);
    step("m_idle",    0, 2'b00, 0, 0, 3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Data-memory busy freezes the front and ignores the branch.
    step("busy",      0, 2'b01, 32'h900, 0, 3'b001, 5'b01111, 5'b10000, 0, 0, 0, 0);
    step("busy_rel",  0, 2'b01, 32'h900, 0, 3'b000, 5'b00000, 5'b00110, 1, 32'h900, 0, 0);

    // Reset in the middle of a killed fetch drops the pending redirect.
    step("r_miss",    0, 2'b00, 0, 0,       3'b100, 5'b00011, 5'b00000, 0, 0, 0, 0);
    step("r_redir",   0, 2'b10, 0, 32'h80,  3'b100, 5'b00001, 5'b00010, 0, 0, 0, 1);
    step("r_kill",    0, 2'b00, 0, 0,       3'b100, 5'b00011, 5'b00000, 0, 0, 0, 2);
    step("r_assert",  1, 2'b00, 0, 0,       3'b100, 5'b00000, 5'b00000, 0, 0, 0, 0);
    step("r_release", 0, 2'b00, 0, 0,       3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);
    step("r_ready",   0, 2'b00, 0, 0,       3'b110, 5'b00000, 5'b00000, 0, 0, 0, 0);
    step("r_after",   0, 2'b00, 0, 0,       3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Redirect during a miss: kill on the ready cycle, replay next.
    step("t4_rst",    1, 2'b00, 0, 0,       3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);
    step("t4_c1",     0, 2'b00, 0, 0,       3'b100, 5'b00011, 5'b00000, 0, 0, 0, 0);
    step("t4_c2",     0, 2'b10, 0, 32'h80,  3'b100, 5'b00001, 5'b00010, 0, 0, 0, 1);
    step("t4_c3",     0, 2'b00, 0, 0,       3'b100, 5'b00011, 5'b00000, 0, 0, 0, 2);
    step("t4_c4",     0, 2'b00, 0, 0,       3'b100, 5'b00011, 5'b00000, 0, 0, 0, 2);
    step("t4_c5",     0, 2'b00, 0, 0,       3'b110, 5'b00000, 5'b00000, 0, 0, 1, 2);
    step("t4_c6",     0, 2'b00, 0, 0,       3'b000, 5'b00000, 5'b00010, 1, 32'h80, 0, 3);
    step("t4_c7",     0, 2'b00, 0, 0,       3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);
`ifdef FC_PERF_CNT_EN
    checks++;
    assert (perf_miss_cyc_o === 32'd4) else begin
      failures++; $error("FAIL perf_miss got=%0d exp=4", perf_miss_cyc_o);
    end
    checks++;
    assert (perf_flush_cnt_o === 32'd2) else begin
      failures++; $error("FAIL perf_flush got=%0d exp=2", perf_flush_cnt_o);
    end
`endif

    // KILL: higher priority overwrites pending, lower/equal is ignored.
    step("p_miss",    0, 2'b00, 0, 0,        3'b100, 5'b00011, 5'b00000, 0, 0, 0, 0);
    step("p_low",     0, 2'b10, 0, 32'h300,  3'b100, 5'b00001, 5'b00010, 0, 0, 0, 1);
    step("p_high",    0, 2'b01, 32'h400, 0,  3'b100, 5'b00001, 5'b00110, 0, 0, 0, 2);
    step("p_ign",     0, 2'b10, 0, 32'h500,  3'b100, 5'b00011, 5'b00000, 0, 0, 0, 2);
    step("p_ready",   0, 2'b00, 0, 0,        3'b110, 5'b00000, 5'b00000, 0, 0, 1, 2);
    step("p_replay",  0, 2'b00, 0, 0,        3'b000, 5'b00000, 5'b00010, 1, 32'h400, 0, 3);
    step("p_idle",    0, 2'b00, 0, 0,        3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Redirect and ready together in MISS: immediate kill, then replay.
    step("q_miss",    0, 2'b00, 0, 0,        3'b100, 5'b00011, 5'b00000, 0, 0, 0, 0);
    step("q_both",    0, 2'b01, 32'h600, 0,  3'b110, 5'b00000, 5'b00110, 0, 0, 1, 1);
    step("q_replay",  0, 2'b00, 0, 0,        3'b000, 5'b00000, 5'b00010, 1, 32'h600, 0, 3);

    // New redirect during REPLAY beats the pending target.
    step("o_miss",    0, 2'b00, 0, 0,        3'b100, 5'b00011, 5'b00000, 0, 0, 0, 0);
    step("o_redir",   0, 2'b10, 0, 32'hA0,   3'b100, 5'b00001, 5'b00010, 0, 0, 0, 1);
    step("o_ready",   0, 2'b00, 0, 0,        3'b110, 5'b00000, 5'b00000, 0, 0, 1, 2);
    step("o_new",     0, 2'b10, 0, 32'h700,  3'b000, 5'b00000, 5'b00010, 1, 32'h700, 0, 3);
    step("o_idle",    0, 2'b00, 0, 0,        3'b000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
